mem_test_sequencer: RTL and testbench
=====================================

# mem_test_sequencer

Parametrised command sequencer for the memory checker. Sits between the CSR block and the transmitter. It expands one CSR-programmed test into a stream of write/read commands with generated addresses. In the checked mode it works in blocks: L writes, then L read-backs of the same addresses. It also counts comparator errors and supports abort and stop-on-error.

## Interface
Clock and reset: one clock; reset is synchronous and active-high (`clk_i`, `rst_i`).

Parameters
- `ADDR_W`, 25: command address width, 2..32.
- `CNT_W`, 16: width of the test length and command counters.
- `BLK_W`, 8: width of the block length used in checked mode.
- `ERR_W`, 16: width of the error counter, which saturates.

Ports
- `clk_i`  in  1  clock.
- `rst_i`  in  1  synchronous active-high reset.
- `start_test_i`  in  1  one-cycle start pulse; sampled only in IDLE.
- `abort_i`  in  1  level; stop issuing commands and drain.
- `test_mode_i`  in  2  `test_mode_t`: READ_ONLY, WRITE_ONLY, WRITE_AND_CHECK.
- `addr_mode_i`  in  3  `addr_mode_t`: FIX, RND, RUN_0, RUN_1, INC, DEC.
- `test_count_i`  in  CNT_W  total data commands (writes or reads; in checked mode, read-backs).
- `blk_len_i`  in  BLK_W  block length L for checked mode; 0 is treated as 1.
- `base_addr_i`  in  ADDR_W  fixed address, or INC/DEC start address.
- `stride_i`  in  ADDR_W  INC/DEC step; 0 is treated as 1.
- `seed_i`  in  ADDR_W  LFSR seed; all-zero is replaced by all-ones.
- `stop_on_err_i`  in  1  first error ends the test.
- `cmp_error_i`  in  1  one-cycle pulse per mismatching word.
- `cmp_busy_i`, `meas_busy_i`, `trans_busy_i`  in  1 each  downstream busy flags.
- `trans_process_i`  in  1  transmitter not accepting; a command is accepted when `trans_valid_o && !trans_process_i`.
- `trans_valid_o`  out  1  command valid; reset 0.
- `trans_addr_o`  out  ADDR_W  command address; reset 0.
- `trans_type_o`  out  1  0 = write, 1 = read; reset 0.
- `test_finish_o`  out  1  one-cycle pulse at test end; reset 0.
- `test_result_o`  out  1  1 if any error was seen in this test; reset 0.
- `err_cnt_o`  out  ERR_W  saturating error count; reset 0.
- `busy_o`  out  1  high whenever the state is not IDLE; reset 0.

## Operation
- States are IDLE, RUN, WR_BLK, RD_BLK, DRAIN.
- IDLE → RUN on start with READ_ONLY or WRITE_ONLY.
- IDLE → WR_BLK on start with WRITE_AND_CHECK.
- IDLE → DRAIN on start when `test_count_i == 0`; this gives a finish pulse with result 0.
- Start latches all CSR inputs. It clears `err_cnt_o` and `test_result_o` and loads the address generator.
- RUN issues `test_count` commands of a single type. After the last accepted command → DRAIN.
- WR_BLK:
  - Block size is B = min(L, remaining).
  - On entry, the generator state is snapshotted.
  - After B accepted writes → RD_BLK, with the generator restored to the snapshot.
- RD_BLK:
  - Issues B reads at the same addresses.
  - Remaining decrements per read.
  - After B reads → DRAIN if remaining is 0, else → WR_BLK.
- Abort, or `cmp_error_i` with stop_on_err set, from any active state → DRAIN.
  - `trans_valid_o` drops next cycle and no further command is issued.
  - A command in its accept cycle counts as issued.
- DRAIN → IDLE when all three busy flags are low. `test_finish_o` pulses in that same transition cycle.
- Errors:
  - Each `cmp_error_i` pulse increments `err_cnt_o`, saturating at all-ones, and sets `test_result_o`.
  - Errors are counted in every state, including DRAIN and IDLE after the test.
  - Start takes priority over an error arriving in the same cycle.
- Address modes; the generator advances on each accepted command:
  - FIX: `base_addr` constant.
  - INC: `base + k·stride`, wrapping modulo 2^ADDR_W.
  - DEC: `base − k·stride`, wrapping modulo 2^ADDR_W.
  - RUN_0: starts at `{1…1,0}`, rotates left.
  - RUN_1: starts at `{0…0,1}`, rotates left.
  - RND: Fibonacci LFSR of width R = 8/16/32 (smallest ≥ ADDR_W), taps from the package, seeded from `seed_i` zero-extended. Output is the low ADDR_W bits.

## Timing
- First `trans_valid_o` is 1 cycle after the start pulse. Address and type are valid in the same cycle.
- Address and type are held stable while `trans_valid_o && trans_process_i`. They update in the cycle after an accept.
- Throughput is one command per cycle while `trans_process_i` is low, including across the WR_BLK/RD_BLK boundary: the next command after the last write is the first read.
- Reset mid-test returns to IDLE and restores every output reset value in the next cycle. No finish pulse is produced.

## Structure
- The package holds:
  - `test_mode_t` and `addr_mode_t`.
  - `lfsr_width(ADDR_W)` and `lfsr_taps(R)` functions, with taps 8:{7,5,4,3}, 16:{15,14,12,3}, 32:{31,21,1,0}.
- One sub-module, `addr_gen`, provides: load, advance, snapshot, restore and current address. The FSM, counters and error logic stay in `mem_test_sequencer`.

## Test plan
- WRITE_ONLY, INC, base 0x10, stride 4, count 5, no backpressure → writes at 0x10, 0x14, 0x18, 0x1C, 0x20 on consecutive cycles; one finish pulse; result 0.
- WRITE_AND_CHECK, count 5, L=2, RUN_1, ADDR_W=8 → W1 W2 R1 R2 W4 W8 R4 R8 W16 R16; finish pulse; err_cnt 0.
- RND, seed 0, random `trans_process_i` → LFSR starts from all-ones and matches the reference model; address and type stay stable while stalled.
- Error injected on the 3rd read with stop_on_err=1 → valid drops next cycle; no more commands; finish pulse after busy flags clear; result 1, err_cnt 1.
- With stop_on_err=0, drive 2^ERR_W+3 error pulses → err_cnt saturates at all-ones; the test runs to count.
- count 0 → finish pulse with no commands; abort mid-test → drain then finish; reset mid-test → all outputs 0, no finish pulse.

Source files
------------

// File: rtl/mem_test_sequencer_pkg.sv
// Shared types and LFSR helpers for the memory test sequencer.
// Imported by the sequencer top and its address generator.
package mem_test_sequencer_pkg;

    typedef enum logic [1:0] {
        READ_ONLY       = 2'd0,
        WRITE_ONLY      = 2'd1,
        WRITE_AND_CHECK = 2'd2
    } test_mode_t;

    typedef enum logic [2:0] {
        FIX   = 3'd0,
        RND   = 3'd1,
        RUN_0 = 3'd2,
        RUN_1 = 3'd3,
        INC   = 3'd4,
        DEC   = 3'd5
    } addr_mode_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_WR_BLK = 3'd2,
        ST_RD_BLK = 3'd3,
        ST_DRAIN  = 3'd4
    } seq_state_t;

    // Smallest supported LFSR width that covers the address.
    function automatic int lfsr_width(input int addr_w);
        if (addr_w <= 8) begin
            return 8;
        end else if (addr_w <= 16) begin
            return 16;
        end
        return 32;
    endfunction

    // Feedback tap mask; bit n set means state bit n feeds the XOR.
    function automatic logic [31:0] lfsr_taps(input int r);
        case (r)
            8:       return 32'h0000_00B8;
            16:      return 32'h0000_D008;
            default: return 32'h8020_0003;
        endcase
    endfunction

endpackage

// File: rtl/mem_test_sequencer_addr_gen.sv
// Address generator: FIX/INC/DEC/walking-bit/LFSR sequences with a
// snapshot register so a block of writes can be replayed as reads.
module mem_test_sequencer_addr_gen
    import mem_test_sequencer_pkg::*;
#(
    parameter int ADDR_W = 25
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  addr_mode_t        mode_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [ADDR_W-1:0] seed_i,
    input  logic              advance_i,
    input  logic              snapshot_i,
    input  logic              restore_i,
    output logic [ADDR_W-1:0] addr_o
);

    localparam int R = lfsr_width(ADDR_W);
    localparam logic [31:0] TAPS_FULL = lfsr_taps(R);
    localparam logic [R-1:0] TAPS = TAPS_FULL[R-1:0];

    addr_mode_t        mode_q, mode_d;
    logic [R-1:0]      cur_q, cur_d;
    logic [R-1:0]      snap_q, snap_d;
    logic [ADDR_W-1:0] stride_q, stride_d;
    logic [R-1:0]      step_val;
    logic [R-1:0]      load_val;
    logic [ADDR_W-1:0] cur_a;

    assign cur_a  = cur_q[ADDR_W-1:0];
    assign addr_o = cur_a;

    always_comb begin
        step_val = cur_q;
        case (mode_q)
            INC: begin
                step_val               = '0;
                step_val[ADDR_W-1:0]   = cur_a + stride_q;
            end
            DEC: begin
                step_val               = '0;
                step_val[ADDR_W-1:0]   = cur_a - stride_q;
            end
            RUN_0, RUN_1: begin
                step_val               = '0;
                step_val[ADDR_W-1:0]   = {cur_a[ADDR_W-2:0], cur_a[ADDR_W-1]};
            end
            RND:     step_val = {cur_q[R-2:0], ^(cur_q & TAPS)};
            default: step_val = cur_q;
        endcase
    end

    always_comb begin
        load_val = '0;
        case (mode_i)
            RUN_0: load_val[ADDR_W-1:0] = ~ADDR_W'(1);
            RUN_1: load_val[ADDR_W-1:0] = ADDR_W'(1);
            RND: begin
                // An all-zero LFSR would lock up, so substitute all-ones.
                if (seed_i == '0) begin
                    load_val = '1;
                end else begin
                    load_val[ADDR_W-1:0] = seed_i;
                end
            end
            default: load_val[ADDR_W-1:0] = base_i;
        endcase
    end

    always_comb begin
        mode_d   = mode_q;
        cur_d    = cur_q;
        snap_d   = snap_q;
        stride_d = stride_q;
        if (load_i) begin
            mode_d   = mode_i;
            cur_d    = load_val;
            snap_d   = load_val;
            stride_d = (stride_i == '0) ? ADDR_W'(1) : stride_i;
        end else begin
            if (restore_i) begin
                cur_d = snap_q;
            end else if (advance_i) begin
                cur_d = step_val;
            end
            // Snapshot captures the post-advance value so the next block
            // starts at the address that follows the last read.
            if (snapshot_i) begin
                snap_d = cur_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mode_q   <= FIX;
            cur_q    <= '0;
            snap_q   <= '0;
            stride_q <= '0;
        end else begin
            mode_q   <= mode_d;
            cur_q    <= cur_d;
            snap_q   <= snap_d;
            stride_q <= stride_d;
        end
    end

endmodule

// File: rtl/mem_test_sequencer.sv
// Expands one CSR-programmed memory test into write/read commands,
// with block-wise write/read-back, abort, stop-on-error and error counting.
module mem_test_sequencer
    import mem_test_sequencer_pkg::*;
#(
    parameter int ADDR_W = 25,
    parameter int CNT_W  = 16,
    parameter int BLK_W  = 8,
    parameter int ERR_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_test_i,
    input  logic              abort_i,
    input  test_mode_t        test_mode_i,
    input  addr_mode_t        addr_mode_i,
    input  logic [CNT_W-1:0]  test_count_i,
    input  logic [BLK_W-1:0]  blk_len_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W-1:0] stride_i,
    input  logic [ADDR_W-1:0] seed_i,
    input  logic              stop_on_err_i,
    input  logic              cmp_error_i,
    input  logic              cmp_busy_i,
    input  logic              meas_busy_i,
    input  logic              trans_busy_i,
    input  logic              trans_process_i,
    output logic              trans_valid_o,
    output logic [ADDR_W-1:0] trans_addr_o,
    output logic              trans_type_o,
    output logic              test_finish_o,
    output logic              test_result_o,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic              busy_o
);

    localparam int MW = (CNT_W > BLK_W) ? CNT_W : BLK_W;

    seq_state_t       state_q, state_d;
    test_mode_t       mode_q, mode_d;
    logic             stop_q, stop_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [BLK_W-1:0] blk_len_q, blk_len_d;
    logic [BLK_W-1:0] blk_size_q, blk_size_d;
    logic [BLK_W-1:0] phase_q, phase_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             result_q, result_d;

    logic             accept;
    logic             halt;
    logic             downstream_idle;
    logic             start_now;
    logic [CNT_W-1:0] rem_dec;
    logic [BLK_W-1:0] blk_len_eff;
    logic [BLK_W-1:0] first_blk;
    logic [BLK_W-1:0] next_blk;
    logic             gen_load, gen_adv, gen_snap, gen_restore;

    function automatic logic [BLK_W-1:0] block_size(input logic [BLK_W-1:0] len,
                                                    input logic [CNT_W-1:0] rem);
        logic [MW-1:0] len_w;
        logic [MW-1:0] rem_w;
        len_w = MW'(len);
        rem_w = MW'(rem);
        return (rem_w < len_w) ? BLK_W'(rem_w) : len;
    endfunction

    assign trans_valid_o   = (state_q == ST_RUN) || (state_q == ST_WR_BLK) || (state_q == ST_RD_BLK);
    assign trans_type_o    = (state_q == ST_RD_BLK) || ((state_q == ST_RUN) && (mode_q == READ_ONLY));
    assign accept          = trans_valid_o && !trans_process_i;
    assign halt            = abort_i || (cmp_error_i && stop_q);
    assign downstream_idle = !cmp_busy_i && !meas_busy_i && !trans_busy_i;
    assign start_now       = (state_q == ST_IDLE) && start_test_i;
    assign rem_dec         = rem_q - CNT_W'(1);
    assign blk_len_eff     = (blk_len_i == '0) ? BLK_W'(1) : blk_len_i;
    assign first_blk       = block_size(blk_len_eff, test_count_i);
    assign next_blk        = block_size(blk_len_q, rem_dec);
    assign test_finish_o   = (state_q == ST_DRAIN) && downstream_idle && !rst_i;
    assign busy_o          = (state_q != ST_IDLE);
    assign test_result_o   = result_q;
    assign err_cnt_o       = err_q;

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        stop_d      = stop_q;
        rem_d       = rem_q;
        blk_len_d   = blk_len_q;
        blk_size_d  = blk_size_q;
        phase_d     = phase_q;
        gen_load    = 1'b0;
        gen_adv     = 1'b0;
        gen_snap    = 1'b0;
        gen_restore = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start_test_i) begin
                    mode_d    = test_mode_i;
                    stop_d    = stop_on_err_i;
                    rem_d     = test_count_i;
                    blk_len_d = blk_len_eff;
                    gen_load  = 1'b1;
                    if (test_count_i == '0) begin
                        state_d = ST_DRAIN;
                    end else if (test_mode_i == WRITE_AND_CHECK) begin
                        blk_size_d = first_blk;
                        phase_d    = first_blk;
                        state_d    = ST_WR_BLK;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (accept) begin
                    gen_adv = 1'b1;
                    rem_d   = rem_dec;
                    if (rem_q == CNT_W'(1)) begin
                        state_d = ST_DRAIN;
                    end
                end
                if (halt) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_WR_BLK: begin
                if (accept) begin
                    if (phase_q == BLK_W'(1)) begin
                        gen_restore = 1'b1;
                        phase_d     = blk_size_q;
                        state_d     = ST_RD_BLK;
                    end else begin
                        gen_adv = 1'b1;
                        phase_d = phase_q - BLK_W'(1);
                    end
                end
                if (halt) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RD_BLK: begin
                if (accept) begin
                    gen_adv = 1'b1;
                    rem_d   = rem_dec;
                    if (phase_q == BLK_W'(1)) begin
                        if (rem_q == CNT_W'(1)) begin
                            state_d = ST_DRAIN;
                        end else begin
                            gen_snap   = 1'b1;
                            blk_size_d = next_blk;
                            phase_d    = next_blk;
                            state_d    = ST_WR_BLK;
                        end
                    end else begin
                        phase_d = phase_q - BLK_W'(1);
                    end
                end
                if (halt) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (downstream_idle) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Start clears the error state even if an error pulse lands in that cycle.
    always_comb begin
        err_d    = err_q;
        result_d = result_q;
        if (start_now) begin
            err_d    = '0;
            result_d = 1'b0;
        end else if (cmp_error_i) begin
            result_d = 1'b1;
            if (err_q != '1) begin
                err_d = err_q + ERR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            mode_q     <= READ_ONLY;
            stop_q     <= 1'b0;
            rem_q      <= '0;
            blk_len_q  <= '0;
            blk_size_q <= '0;
            phase_q    <= '0;
            err_q      <= '0;
            result_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            stop_q     <= stop_d;
            rem_q      <= rem_d;
            blk_len_q  <= blk_len_d;
            blk_size_q <= blk_size_d;
            phase_q    <= phase_d;
            err_q      <= err_d;
            result_q   <= result_d;
        end
    end

    mem_test_sequencer_addr_gen #(
        .ADDR_W (ADDR_W)
    ) u_addr_gen (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (gen_load),
        .mode_i     (addr_mode_i),
        .base_i     (base_addr_i),
        .stride_i   (stride_i),
        .seed_i     (seed_i),
        .advance_i  (gen_adv),
        .snapshot_i (gen_snap),
        .restore_i  (gen_restore),
        .addr_o     (trans_addr_o)
    );

endmodule

// File: tb/tb_mem_test_sequencer.sv
// Directed bench for mem_test_sequencer: expected commands are queued
// when a test is started and compared as the DUT issues them.
`timescale 1ns/1ps
module tb_mem_test_sequencer;
    import mem_test_sequencer_pkg::*;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;
    localparam int BLK_W  = 8;
    localparam int ERR_W  = 4;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              start_test_i;
    logic              abort_i;
    test_mode_t        test_mode_i;
    addr_mode_t        addr_mode_i;
    logic [CNT_W-1:0]  test_count_i;
    logic [BLK_W-1:0]  blk_len_i;
    logic [ADDR_W-1:0] base_addr_i;
    logic [ADDR_W-1:0] stride_i;
    logic [ADDR_W-1:0] seed_i;
    logic              stop_on_err_i;
    logic              cmp_error_i;
    logic              cmp_busy_i;
    logic              meas_busy_i;
    logic              trans_busy_i;
    logic              trans_process_i;
    logic              trans_valid_o;
    logic [ADDR_W-1:0] trans_addr_o;
    logic              trans_type_o;
    logic              test_finish_o;
    logic              test_result_o;
    logic [ERR_W-1:0]  err_cnt_o;
    logic              busy_o;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic              typ;
    } cmd_t;

    cmd_t exp_q[$];
    int   n_checks  = 0;
    int   n_pass    = 0;
    int   fin_cnt   = 0;
    int   acc_cnt   = 0;
    int   cyc       = 0;
    int   first_acc = -1;
    int   last_acc  = -1;

    always #5 clk = ~clk;

    mem_test_sequencer #(
        .ADDR_W (ADDR_W),
        .CNT_W  (CNT_W),
        .BLK_W  (BLK_W),
        .ERR_W  (ERR_W)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_test_i    (start_test_i),
        .abort_i         (abort_i),
        .test_mode_i     (test_mode_i),
        .addr_mode_i     (addr_mode_i),
        .test_count_i    (test_count_i),
        .blk_len_i       (blk_len_i),
        .base_addr_i     (base_addr_i),
        .stride_i        (stride_i),
        .seed_i          (seed_i),
        .stop_on_err_i   (stop_on_err_i),
        .cmp_error_i     (cmp_error_i),
        .cmp_busy_i      (cmp_busy_i),
        .meas_busy_i     (meas_busy_i),
        .trans_busy_i    (trans_busy_i),
        .trans_process_i (trans_process_i),
        .trans_valid_o   (trans_valid_o),
        .trans_addr_o    (trans_addr_o),
        .trans_type_o    (trans_type_o),
        .test_finish_o   (test_finish_o),
        .test_result_o   (test_result_o),
        .err_cnt_o       (err_cnt_o),
        .busy_o          (busy_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    function automatic cmd_t mk(input logic [ADDR_W-1:0] a, input logic t);
        cmd_t c;
        c.addr = a;
        c.typ  = t;
        return c;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every presented command (stalled or not) to the queue head.
    always @(negedge clk) begin
        if (test_finish_o) fin_cnt++;
        if (trans_valid_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_cmd", 32'(trans_valid_o), 32'd0);
            end else begin
                check("cmd_addr", 32'(trans_addr_o), 32'(exp_q[0].addr));
                check("cmd_type", 32'(trans_type_o), 32'(exp_q[0].typ));
                if (!trans_process_i) begin
                    $display("cmd %0d: %s addr=0x%0h at cycle %0d", acc_cnt,
                             trans_type_o ? "RD" : "WR", trans_addr_o, cyc);
                    void'(exp_q.pop_front());
                    acc_cnt++;
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic configure(input test_mode_t tm, input addr_mode_t am, input int cnt,
                             input int len, input logic [ADDR_W-1:0] base,
                             input logic [ADDR_W-1:0] stride, input logic [ADDR_W-1:0] seed,
                             input logic soe);
        test_mode_i   = tm;
        addr_mode_i   = am;
        test_count_i  = CNT_W'(cnt);
        blk_len_i     = BLK_W'(len);
        base_addr_i   = base;
        stride_i      = stride;
        seed_i        = seed;
        stop_on_err_i = soe;
        first_acc     = -1;
        last_acc      = -1;
    endtask

    task automatic pulse_start();
        tick();
        start_test_i = 1'b1;
        tick();
        start_test_i = 1'b0;
    endtask

    task automatic wait_finish(input string tag, input int budget, input bit rnd_bp);
        int f0;
        int n;
        f0 = fin_cnt;
        n  = 0;
        while (fin_cnt == f0 && n < budget) begin
            if (rnd_bp) trans_process_i = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        trans_process_i = 1'b0;
        check({tag, "_finish_pulses"}, 32'(fin_cnt - f0), 32'd1);
        check({tag, "_queue_empty"}, 32'(exp_q.size()), 32'd0);
        check({tag, "_busy_after"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [ADDR_W-1:0] t2_addr [10];
        logic              t2_typ  [10];
        logic [ADDR_W-1:0] s;
        int                f0;

        rst_i = 1'b1; start_test_i = 1'b0; abort_i = 1'b0; cmp_error_i = 1'b0;
        cmp_busy_i = 1'b0; meas_busy_i = 1'b0; trans_busy_i = 1'b0; trans_process_i = 1'b0;
        configure(READ_ONLY, FIX, 0, 0, '0, '0, '0, 1'b0);
        repeat (3) tick();
        check("rst_valid",  32'(trans_valid_o), 32'd0);
        check("rst_addr",   32'(trans_addr_o),  32'd0);
        check("rst_type",   32'(trans_type_o),  32'd0);
        check("rst_finish", 32'(test_finish_o), 32'd0);
        check("rst_result", 32'(test_result_o), 32'd0);
        check("rst_errcnt", 32'(err_cnt_o),     32'd0);
        check("rst_busy",   32'(busy_o),        32'd0);
        rst_i = 1'b0;
        tick();

        // WRITE_ONLY, INC: 0x10..0x20 back to back
        configure(WRITE_ONLY, INC, 5, 1, 8'h10, 8'h04, 8'h00, 1'b0);
        for (int k = 0; k < 5; k++) exp_q.push_back(mk(8'(8'h10 + 4 * k), 1'b0));
        pulse_start();
        check("t1_first_valid", 32'(trans_valid_o), 32'd1);
        wait_finish("t1", 50, 1'b0);
        check("t1_span", 32'(last_acc - first_acc), 32'd4);
        check("t1_result", 32'(test_result_o), 32'd0);

        // WRITE_AND_CHECK, RUN_1, L=2, count 5
        t2_addr = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd4, 8'd8, 8'd4, 8'd8, 8'd16, 8'd16};
        t2_typ  = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        configure(WRITE_AND_CHECK, RUN_1, 5, 2, 8'h00, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 10; k++) exp_q.push_back(mk(t2_addr[k], t2_typ[k]));
        pulse_start();
        wait_finish("t2", 60, 1'b0);
        check("t2_span", 32'(last_acc - first_acc), 32'd9);
        check("t2_errcnt", 32'(err_cnt_o), 32'd0);

        // RND with seed 0 under random backpressure
        configure(READ_ONLY, RND, 16, 1, 8'h00, 8'h00, 8'h00, 1'b0);
        s = 8'hFF;
        for (int k = 0; k < 16; k++) begin
            exp_q.push_back(mk(s, 1'b1));
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end
        pulse_start();
        wait_finish("t3", 400, 1'b1);
        check("t3_result", 32'(test_result_o), 32'd0);

        // stop-on-error on the 3rd read
        configure(READ_ONLY, INC, 8, 1, 8'h40, 8'h01, 8'h00, 1'b1);
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(8'(8'h40 + k), 1'b1));
        pulse_start();
        tick();
        tick();
        cmp_error_i = 1'b1;
        cmp_busy_i  = 1'b1;
        tick();
        cmp_error_i = 1'b0;
        check("t4_valid_drop", 32'(trans_valid_o), 32'd0);
        f0 = fin_cnt;
        repeat (4) tick();
        check("t4_busy_while_drain", 32'(busy_o), 32'd1);
        check("t4_no_early_finish", 32'(fin_cnt - f0), 32'd0);
        cmp_busy_i = 1'b0;
        wait_finish("t4", 20, 1'b0);
        check("t4_result", 32'(test_result_o), 32'd1);
        check("t4_errcnt", 32'(err_cnt_o), 32'd1);

        // error counter saturation, test keeps running
        configure(WRITE_ONLY, FIX, 6, 1, 8'hA5, 8'h00, 8'h00, 1'b0);
        for (int k = 0; k < 6; k++) exp_q.push_back(mk(8'hA5, 1'b0));
        trans_process_i = 1'b1;
        pulse_start();
        for (int i = 0; i < (1 << ERR_W) + 3; i++) begin
            cmp_error_i = 1'b1;
            tick();
            cmp_error_i = 1'b0;
            tick();
            if (i == 2) check("t5_errcnt_partial", 32'(err_cnt_o), 32'd3);
        end
        check("t5_errcnt_sat", 32'(err_cnt_o), 32'((1 << ERR_W) - 1));
        check("t5_still_busy", 32'(busy_o), 32'd1);
        check("t5_result", 32'(test_result_o), 32'd1);
        trans_process_i = 1'b0;
        wait_finish("t5", 30, 1'b0);
        check("t5_errcnt_end", 32'(err_cnt_o), 32'((1 << ERR_W) - 1));

        // count 0, with an error arriving in the start cycle
        configure(WRITE_ONLY, INC, 0, 1, 8'h10, 8'h01, 8'h00, 1'b0);
        tick();
        start_test_i = 1'b1;
        cmp_error_i  = 1'b1;
        tick();
        start_test_i = 1'b0;
        cmp_error_i  = 1'b0;
        check("t6_errcnt_cleared", 32'(err_cnt_o), 32'd0);
        check("t6_result_cleared", 32'(test_result_o), 32'd0);
        wait_finish("t6", 10, 1'b0);
        check("t6_result", 32'(test_result_o), 32'd0);

        // abort mid-test, DEC wrapping through zero
        configure(READ_ONLY, DEC, 20, 1, 8'h05, 8'h03, 8'h00, 1'b0);
        exp_q.push_back(mk(8'h05, 1'b1));
        exp_q.push_back(mk(8'h02, 1'b1));
        exp_q.push_back(mk(8'hFF, 1'b1));
        pulse_start();
        tick();
        tick();
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t7_valid_drop", 32'(trans_valid_o), 32'd0);
        wait_finish("t7", 20, 1'b0);
        check("t7_result", 32'(test_result_o), 32'd0);

        // reset mid-test
        configure(WRITE_ONLY, INC, 20, 1, 8'h10, 8'h01, 8'h00, 1'b0);
        for (int k = 0; k < 20; k++) exp_q.push_back(mk(8'(8'h10 + k), 1'b0));
        pulse_start();
        cmp_error_i = 1'b1;
        tick();
        cmp_error_i = 1'b0;
        rst_i = 1'b1;
        f0 = fin_cnt;
        tick();
        check("t8_valid",  32'(trans_valid_o), 32'd0);
        check("t8_addr",   32'(trans_addr_o),  32'd0);
        check("t8_type",   32'(trans_type_o),  32'd0);
        check("t8_finish", 32'(test_finish_o), 32'd0);
        check("t8_result", 32'(test_result_o), 32'd0);
        check("t8_errcnt", 32'(err_cnt_o),     32'd0);
        check("t8_busy",   32'(busy_o),        32'd0);
        rst_i = 1'b0;
        exp_q.delete();
        repeat (5) tick();
        check("t8_no_finish", 32'(fin_cnt - f0), 32'd0);
        check("t8_idle", 32'(busy_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
